// File: rtl/uart_rx.sv
// 8N1 UART receiver with an internal oversampling tick generator and valid/ready output hold.
// Define UART_RX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module uart_rx #(
  parameter int CLK_rate   = 100000000,
  parameter int Baud_rate  = 9600,
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       rx_i,
  output logic [7:0] data_o,
  output logic       valid_o,
  input  logic       ready_i,
  output logic       frame_err_o,
  output logic       overrun_o,
  output logic       parity_err_o
);

  localparam int DIV   = CLK_rate / (Baud_rate * OVERSAMPLE);
  localparam int CNT_W = $clog2(DIV) + 1;
  localparam int SMP_W = $clog2(OVERSAMPLE);
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DIV - 1);
  localparam logic [SMP_W-1:0] SMP_LAST = SMP_W'(OVERSAMPLE - 1);
  localparam logic [SMP_W-1:0] SMP_A    = SMP_W'(OVERSAMPLE / 2 - 1);
  localparam logic [SMP_W-1:0] SMP_B    = SMP_W'(OVERSAMPLE / 2);
  localparam logic [SMP_W-1:0] SMP_C    = SMP_W'(OVERSAMPLE / 2 + 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;

  state_e           state_q, state_d;
  logic [1:0]       sync_q;
  logic             rx_prev_q;
  logic [CNT_W-1:0] div_q, div_d;
  logic [SMP_W-1:0] smp_q, smp_d;
  logic [1:0]       win_q, win_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       data_q, data_d;
  logic             valid_q, valid_d;
  logic             ferr_q, ovr_q;
  logic             rx_s, tick, decide, bit_val, par_bad;
  logic             start_clr, shift_en, stop_dec, load, ferr, perr;

  assign rx_s    = sync_q[1];
  assign tick    = (div_q == DIV_LAST);
  assign decide  = tick && (smp_q == SMP_C);
  assign bit_val = (win_q[0] & win_q[1]) | (win_q[0] & rx_s) | (win_q[1] & rx_s);

`ifdef UART_RX_PARITY_EN
  logic par_q, par_en, perr_q;
  assign par_bad      = ^{shift_q, par_q};
  assign par_en       = (state_q == PARITY) && decide;
  assign parity_err_o = perr_q;
`else
  assign par_bad      = 1'b0;
  assign parity_err_o = 1'b0;
`endif

  // NOTE: every register is reset synchronously inside the clocked block; no async path.
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Only a falling edge of the synced line starts a frame, so a held break cannot re-trigger.
  always_comb begin
    // NOTE: default first so every path assigns state_d and no latch is inferred.
    state_d = state_q;
    case (state_q)
      IDLE:   if (rx_prev_q && !rx_s) state_d = START;
      START:  if (decide) state_d = bit_val ? IDLE : DATA;
`ifdef UART_RX_PARITY_EN
      DATA:   if (decide && idx_q == 3'd7) state_d = PARITY;
`else
      DATA:   if (decide && idx_q == 3'd7) state_d = STOP;
`endif
      PARITY: if (decide) state_d = STOP;
      STOP:   if (decide) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    start_clr = (state_q == IDLE) && (state_d == START);
    shift_en  = (state_q == DATA) && decide;
    stop_dec  = (state_q == STOP) && decide;
    load      = stop_dec && bit_val && !par_bad;
    ferr      = stop_dec && !bit_val;
    perr      = stop_dec && par_bad;
  end

  always_comb begin
    div_d = (start_clr || tick) ? '0 : div_q + CNT_W'(1);
    smp_d = smp_q;
    if (start_clr)  smp_d = '0;
    else if (tick)  smp_d = (smp_q == SMP_LAST) ? '0 : smp_q + SMP_W'(1);
    win_d = win_q;
    if (tick && smp_q == SMP_A) win_d[0] = rx_s;
    if (tick && smp_q == SMP_B) win_d[1] = rx_s;
    idx_d = idx_q;
    if (start_clr)     idx_d = 3'd0;
    else if (shift_en) idx_d = idx_q + 3'd1;
    shift_d = shift_en ? {bit_val, shift_q[7:1]} : shift_q;
    data_d  = load ? shift_q : data_q;
    // An accept in the same clock as a load is absorbed: valid stays set, no overrun.
    valid_d = load | (valid_q & ~ready_i);
  end

  // NOTE: non-blocking assignments so all registers update together on the edge.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q    <= 2'b11;
      rx_prev_q <= 1'b1;
      div_q     <= '0;
      smp_q     <= '0;
      win_q     <= 2'b00;
      idx_q     <= 3'd0;
      shift_q   <= 8'h00;
      data_q    <= 8'h00;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      sync_q    <= {sync_q[0], rx_i};
      rx_prev_q <= rx_s;
      div_q     <= div_d;
      smp_q     <= smp_d;
      win_q     <= win_d;
      idx_q     <= idx_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr;
      ovr_q     <= load & valid_q & ~ready_i;
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      par_q  <= 1'b0;
      perr_q <= 1'b0;
    end else begin
      if (par_en) par_q <= bit_val;
      perr_q <= perr;
    end
  end
`endif

  assign data_o      = data_q;
  assign valid_o     = valid_q;
  assign frame_err_o = ferr_q;
  assign overrun_o   = ovr_q;

endmodule
